// File: rtl/pwm_regs_pkg.sv
// rtl/pwm_regs_pkg.sv - shared offsets and bit positions for the PWM register bank
package pwm_regs_pkg;

    localparam int CH_STRIDE = 32;
    localparam int CTRL_W    = 5;

    localparam logic [4:0] OFF_PERIOD = 5'h00;
    localparam logic [4:0] OFF_CMP1   = 5'h04;
    localparam logic [4:0] OFF_CMP2   = 5'h08;
    localparam logic [4:0] OFF_CNT    = 5'h0C;
    localparam logic [4:0] OFF_CTRL   = 5'h10;
    localparam logic [4:0] OFF_PRESC  = 5'h11;
    localparam logic [4:0] OFF_FUNC   = 5'h12;
    localparam logic [4:0] OFF_CMD    = 5'h13;
    localparam logic [4:0] OFF_STATUS = 5'h14;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_UPDN      = 1;
    localparam int CTRL_PWM_EN    = 2;
    localparam int CTRL_SHADOW_EN = 3;
    localparam int CTRL_IRQ_EN    = 4;

    localparam int CMD_CNT_RST    = 0;
    localparam int CMD_FORCE_UPD  = 1;

    localparam int STAT_OVF       = 0;
    localparam int STAT_UPD_PEND  = 1;

endpackage

// File: rtl/pwm_regs_ch.sv
// rtl/pwm_regs_ch.sv - one channel: staging/active registers, shadow transfer, reset pulse, overflow
module pwm_regs_ch
    import pwm_regs_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int RST_PULSE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [4:0]       off_i,
    input  logic [7:0]       wdata_i,
    input  logic [CNT_W-1:0] counter_val_i,
    input  logic             period_evt_i,
    output logic [7:0]       rdata_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] compare1_o,
    output logic [CNT_W-1:0] compare2_o,
    output logic             en_o,
    output logic             upnotdown_o,
    output logic             pwm_en_o,
    output logic             count_reset_o,
    output logic [7:0]       prescale_o,
    output logic [7:0]       functions_o,
    output logic             irq_req_o
);

    localparam int NB = CNT_W / 8;

    // index 0 = period, 1 = compare1, 2 = compare2
    logic [CNT_W-1:0]  stg_q [3];
    logic [CNT_W-1:0]  stg_d [3];
    logic [CNT_W-1:0]  act_q [3];
    logic [CNT_W-1:0]  act_d [3];
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [7:0]        presc_q, presc_d;
    logic [7:0]        func_q, func_d;
    logic              pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic [3:0]        pulse_q, pulse_d;

    logic lane_ok;
    logic stg_wr;
    logic cmd_wr;
    logic status_wr;
    logic xfer;

    assign lane_ok   = 32'(off_i[1:0]) < NB;
    assign stg_wr    = wr_i && (off_i < OFF_CNT) && lane_ok;
    assign cmd_wr    = wr_i && (off_i == OFF_CMD);
    assign status_wr = wr_i && (off_i == OFF_STATUS);
    assign xfer      = !ctrl_q[CTRL_SHADOW_EN]
                     || (pend_q && (period_evt_i || (cmd_wr && wdata_i[CMD_FORCE_UPD])));

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            stg_d[k] = stg_q[k];
            act_d[k] = act_q[k];
        end
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        func_d  = func_q;
        pulse_d = pulse_q;

        if (stg_wr) begin
            stg_d[off_i[3:2]][8*off_i[1:0] +: 8] = wdata_i;
        end
        if (wr_i) begin
            case (off_i)
                OFF_CTRL:  ctrl_d  = wdata_i[CTRL_W-1:0];
                OFF_PRESC: presc_d = wdata_i;
                OFF_FUNC:  func_d  = wdata_i;
                default:   ;
            endcase
        end

        // the transfer samples staging-next so a coincident byte write is carried along
        if (xfer) begin
            for (int k = 0; k < 3; k++) begin
                act_d[k] = stg_d[k];
            end
        end
        pend_d = ctrl_q[CTRL_SHADOW_EN] && !xfer && (pend_q || stg_wr);

        if (cmd_wr && wdata_i[CMD_CNT_RST]) begin
            pulse_d = 4'(RST_PULSE);
        end else if (pulse_q != 4'd0) begin
            pulse_d = pulse_q - 4'd1;
        end

        ovf_d = period_evt_i || (ovf_q && !(status_wr && wdata_i[STAT_OVF]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                stg_q[k] <= '0;
                act_q[k] <= '0;
            end
            ctrl_q  <= '0;
            presc_q <= '0;
            func_q  <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pulse_q <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                stg_q[k] <= stg_d[k];
                act_q[k] <= act_d[k];
            end
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            func_q  <= func_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        rdata_o = 8'h00;
        if (off_i < OFF_CNT) begin
            if (lane_ok) rdata_o = stg_q[off_i[3:2]][8*off_i[1:0] +: 8];
        end else if (off_i < OFF_CTRL) begin
            if (lane_ok) rdata_o = counter_val_i[8*off_i[1:0] +: 8];
        end else begin
            case (off_i)
                OFF_CTRL:   rdata_o = {{(8-CTRL_W){1'b0}}, ctrl_q};
                OFF_PRESC:  rdata_o = presc_q;
                OFF_FUNC:   rdata_o = func_q;
                OFF_STATUS: begin
                    rdata_o[STAT_OVF]      = ovf_q;
                    rdata_o[STAT_UPD_PEND] = pend_q;
                end
                default:    ;
            endcase
        end
    end

    assign period_o      = act_q[0];
    assign compare1_o    = act_q[1];
    assign compare2_o    = act_q[2];
    assign en_o          = ctrl_q[CTRL_EN];
    assign upnotdown_o   = ctrl_q[CTRL_UPDN];
    assign pwm_en_o      = ctrl_q[CTRL_PWM_EN];
    assign count_reset_o = (pulse_q != 4'd0);
    assign prescale_o    = presc_q;
    assign functions_o   = func_q;
    assign irq_req_o     = ovf_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/pwm_regs_mc.sv
// rtl/pwm_regs_mc.sv - multi-channel PWM register bank: channel decode, read mux, irq
module pwm_regs_mc
    import pwm_regs_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int CNT_W     = 16,
    parameter int ADDR_W    = 8,
    parameter int RST_PULSE = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_W-1:0]       addr,
    output logic [7:0]              data_read,
    input  logic [7:0]              data_write,
    input  logic [NUM_CH*CNT_W-1:0] counter_val,
    input  logic [NUM_CH-1:0]       period_evt,
    output logic [NUM_CH*CNT_W-1:0] period,
    output logic [NUM_CH*CNT_W-1:0] compare1,
    output logic [NUM_CH*CNT_W-1:0] compare2,
    output logic [NUM_CH-1:0]       en,
    output logic [NUM_CH-1:0]       upnotdown,
    output logic [NUM_CH-1:0]       pwm_en,
    output logic [NUM_CH-1:0]       count_reset,
    output logic [NUM_CH*8-1:0]     prescale,
    output logic [NUM_CH*8-1:0]     functions,
    output logic                    irq
);

    localparam int CH_SHIFT = $clog2(CH_STRIDE);

    logic [31:0]       ch_num;
    logic [4:0]        off;
    logic [7:0]        rbyte [NUM_CH];
    logic [NUM_CH-1:0] irq_req;
    logic              irq_q, irq_d;

    assign ch_num = 32'(addr[ADDR_W-1:CH_SHIFT]);
    assign off    = addr[CH_SHIFT-1:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_regs_ch #(
            .CNT_W     (CNT_W),
            .RST_PULSE (RST_PULSE)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .wr_i          (write && (ch_num == 32'(i))),
            .off_i         (off),
            .wdata_i       (data_write),
            .counter_val_i (counter_val[i*CNT_W +: CNT_W]),
            .period_evt_i  (period_evt[i]),
            .rdata_o       (rbyte[i]),
            .period_o      (period[i*CNT_W +: CNT_W]),
            .compare1_o    (compare1[i*CNT_W +: CNT_W]),
            .compare2_o    (compare2[i*CNT_W +: CNT_W]),
            .en_o          (en[i]),
            .upnotdown_o   (upnotdown[i]),
            .pwm_en_o      (pwm_en[i]),
            .count_reset_o (count_reset[i]),
            .prescale_o    (prescale[i*8 +: 8]),
            .functions_o   (functions[i*8 +: 8]),
            .irq_req_o     (irq_req[i])
        );
    end

    // addresses beyond the last channel match no channel and read 0x00
    always_comb begin
        data_read = 8'h00;
        if (read) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_num == 32'(i)) data_read = rbyte[i];
            end
        end
    end

    assign irq_d = |irq_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q;

endmodule
